fetch_unit: RTL

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC and runs a request/ready handshake to instruction memory. Each cycle it presents the fetched 16-bit instruction, PC+step, a load strobe (IFIDWrite) and a flush strobe (IFFlush) to the IF/ID register. It honours hazard-unit stalls through pcWrite and branch redirects from the ID/EX stage.

---
 rtl/fetch_unit_pkg.sv | 11 +
 rtl/fetch_unit_pc.sv | 22 ++
 rtl/fetch_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, FSM encoding and NOP value for the fetch stage
package fetch_unit_pkg;
   localparam int INSTR_W = 16;
   localparam int ADDR_W = 16;
   localparam logic [INSTR_W-1:0] NOP = 16'h0000;
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/fetch_unit_pc.sv
// pc_register: program counter with async reset, redirect load and step increment
module pc_register
   import fetch_unit_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
   parameter logic [ADDR_W-1:0] PC_STEP  = 16'd2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_inc
);
   assign pc_inc = pc + PC_STEP;
   // a redirect always wins over sequential progress
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pc <= RESET_PC;
      else if (load) pc <= target;
      else if (inc) pc <= pc_inc;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC and drives a req/ready fetch into the IF/ID register
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
   parameter logic [ADDR_W-1:0] PC_STEP  = 16'd2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pcWrite,
   input  logic               branchTaken,
   input  logic [ADDR_W-1:0]  branchTarget,
   output logic               imemReq,
   output logic [ADDR_W-1:0]  imemAddr,
   input  logic               imemReady,
   input  logic [INSTR_W-1:0] imemData,
   output logic [INSTR_W-1:0] instruction,
   output logic [ADDR_W-1:0]  updatedPC,
   output logic               IFIDWrite,
   output logic               IFFlush
);
   fetch_state_t state, state_n;
   logic [ADDR_W-1:0] pc, pc_inc, drain_addr, addr;
   logic [INSTR_W-1:0] hold_instr, instr;
   logic pc_load, pc_inc_en, hold_ld, drain_ld, req, wr;

   pc_register #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (pc_load),
      .inc    (pc_inc_en),
      .target (branchTarget),
      .pc     (pc),
      .pc_inc (pc_inc)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= FETCH;
         hold_instr <= NOP;
         drain_addr <= '0;
      end else begin
         state <= state_n;
         if (hold_ld) hold_instr <= imemData;
         if (drain_ld) drain_addr <= pc;
      end

   always_comb begin
      state_n   = state;
      pc_load   = 1'b0;
      pc_inc_en = 1'b0;
      hold_ld   = 1'b0;
      drain_ld  = 1'b0;
      req       = 1'b0;
      wr        = 1'b0;
      addr      = pc;
      instr     = NOP;
      case (state)
         FETCH: begin
            req   = 1'b1;
            instr = imemData;
            if (branchTaken) begin
               pc_load  = 1'b1;
               drain_ld = !imemReady;
               state_n  = imemReady ? FETCH : DRAIN;
            end else if (imemReady) begin
               wr        = pcWrite;
               pc_inc_en = pcWrite;
               hold_ld   = !pcWrite;
               state_n   = pcWrite ? FETCH : HOLD;
            end
         end
         HOLD: begin
            instr     = hold_instr;
            pc_load   = branchTaken;
            pc_inc_en = pcWrite;
            wr        = pcWrite && !branchTaken;
            state_n   = (branchTaken || pcWrite) ? FETCH : HOLD;
         end
         DRAIN: begin
            // keep the in-flight request on its original address until it completes
            req     = 1'b1;
            addr    = drain_addr;
            pc_load = branchTaken;
            state_n = imemReady ? FETCH : DRAIN;
         end
         default: state_n = FETCH;
      endcase
   end

   // strobes are forced quiet while reset is asserted, abandoning any request at once
   assign imemReq     = rst_n && req;
   assign imemAddr    = addr;
   assign instruction = rst_n ? instr : NOP;
   assign updatedPC   = pc_inc;
   assign IFIDWrite   = rst_n && wr;
   assign IFFlush     = rst_n && branchTaken;
endmodule
